// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        CLOSING
    } gate_state_t;

    localparam int HOLD_W = 4;

    localparam logic CLASS_UNI = 1'b1;
    localparam logic CLASS_PUB = 1'b0;

endpackage

// File: rtl/parking_gate_fsm.sv
// One barrier: request edge detect, IDLE/OPEN/CLOSING FSM,
// saturating open timeout and close hold counters.
module parking_gate_fsm
    import parking_pkg::*;
#(
    parameter int OPEN_TIMEOUT = 100,
    parameter int CLOSE_HOLD   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic is_uni,
    input  logic pass,
    input  logic check_en,
    input  logic vacant,
    output logic barrier_up,
    output logic denied,
    output logic event_valid,
    output logic event_uni
);

    localparam int TO_W = $clog2(OPEN_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(OPEN_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX = {TO_W{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLOSE_HOLD - 1);

    gate_state_t state, state_n;
    logic req_q;
    logic rise;
    logic cls, cls_n;
    logic denied_n;
    logic [TO_W-1:0] to_cnt, to_cnt_n;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;

    assign rise = req & ~req_q;
    assign barrier_up = (state == OPEN);
    assign event_uni = cls;

    always_comb begin
        state_n = state;
        cls_n = cls;
        to_cnt_n = to_cnt;
        hold_cnt_n = hold_cnt;
        denied_n = 1'b0;
        event_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    cls_n = is_uni;
                    to_cnt_n = '0;
                    if (check_en && !vacant) begin
                        denied_n = 1'b1;
                    end else begin
                        state_n = OPEN;
                    end
                end
            end
            OPEN: begin
                // A pass on the timeout cycle still counts as a car.
                if (pass) begin
                    event_valid = 1'b1;
                    state_n = CLOSING;
                    hold_cnt_n = '0;
                end else if (to_cnt == TO_LAST) begin
                    state_n = CLOSING;
                    hold_cnt_n = '0;
                end else if (to_cnt != TO_MAX) begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end
            CLOSING: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_n = IDLE;
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // req_q resets high so a request held through reset is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            req_q <= 1'b1;
            cls <= CLASS_PUB;
            to_cnt <= '0;
            hold_cnt <= '0;
            denied <= 1'b0;
        end else begin
            state <= state_n;
            req_q <= req;
            cls <= cls_n;
            to_cnt <= to_cnt_n;
            hold_cnt <= hold_cnt_n;
            denied <= denied_n;
        end
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit barrier controller feeding the occupancy counter.
// Optional PARKING_GATE_DENY_CNT_EN adds a saturating deny_count.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int OPEN_TIMEOUT = 100,
    parameter int CLOSE_HOLD   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_req,
    input  logic       entry_is_uni,
    input  logic       entry_pass,
    input  logic       exit_req,
    input  logic       exit_is_uni,
    input  logic       exit_pass,
    input  logic       uni_is_vacated_space,
    input  logic       is_vacated_space,
    output logic       car_entered,
    output logic       is_uni_car_entered,
    output logic       car_exited,
    output logic       is_uni_car_exited,
    output logic       entry_barrier_up,
    output logic       exit_barrier_up,
    output logic       entry_denied
`ifdef PARKING_GATE_DENY_CNT_EN
    ,
    output logic [9:0] deny_count
`endif
);

    logic ent_vacant;
    logic ent_ev, ent_uni;
    logic ex_ev, ex_uni;
    logic ex_denied_unused;
    logic pend_v, pend_uni;

    assign ent_vacant = (entry_is_uni == CLASS_UNI) ? uni_is_vacated_space
                                                    : is_vacated_space;

    parking_gate_fsm #(
        .OPEN_TIMEOUT(OPEN_TIMEOUT),
        .CLOSE_HOLD  (CLOSE_HOLD)
    ) u_entry (
        .clk        (clk),
        .rst        (rst),
        .req        (entry_req),
        .is_uni     (entry_is_uni),
        .pass       (entry_pass),
        .check_en   (1'b1),
        .vacant     (ent_vacant),
        .barrier_up (entry_barrier_up),
        .denied     (entry_denied),
        .event_valid(ent_ev),
        .event_uni  (ent_uni)
    );

    parking_gate_fsm #(
        .OPEN_TIMEOUT(OPEN_TIMEOUT),
        .CLOSE_HOLD  (CLOSE_HOLD)
    ) u_exit (
        .clk        (clk),
        .rst        (rst),
        .req        (exit_req),
        .is_uni     (exit_is_uni),
        .pass       (exit_pass),
        .check_en   (1'b0),
        .vacant     (1'b1),
        .barrier_up (exit_barrier_up),
        .denied     (ex_denied_unused),
        .event_valid(ex_ev),
        .event_uni  (ex_uni)
    );

    // Entry wins the counter's single event slot; exit waits one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            car_entered <= 1'b0;
            is_uni_car_entered <= CLASS_PUB;
            car_exited <= 1'b0;
            is_uni_car_exited <= CLASS_PUB;
            pend_v <= 1'b0;
            pend_uni <= CLASS_PUB;
        end else begin
            car_entered <= ent_ev;
            is_uni_car_entered <= ent_ev ? ent_uni : CLASS_PUB;
            if (ent_ev) begin
                car_exited <= 1'b0;
                is_uni_car_exited <= CLASS_PUB;
                if (ex_ev) begin
                    pend_v <= 1'b1;
                    pend_uni <= ex_uni;
                end
            end else if (pend_v) begin
                car_exited <= 1'b1;
                is_uni_car_exited <= pend_uni;
                pend_v <= ex_ev;
                pend_uni <= ex_uni;
            end else begin
                car_exited <= ex_ev;
                is_uni_car_exited <= ex_ev ? ex_uni : CLASS_PUB;
            end
        end
    end

`ifdef PARKING_GATE_DENY_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deny_count <= '0;
        end else if (entry_denied && deny_count != 10'h3FF) begin
            deny_count <= deny_count + 10'd1;
        end
    end
`endif

endmodule
